clock_period_meter: RTL

- Measures the period and high time of a slow, asynchronous square-wave input, counted in cycles of the system clock `clkin`.
- Consumer end of the divided-clock path: it checks and reports what a divider output actually produces, for on-board self-test and LED/7-seg display logic.
- Synchronises the input, detects rising edges, counts continuously, publishes one result per input period, and flags loss of signal with a timeout.

---
 rtl/clock_period_meter_if.sv | 33 +++
 rtl/clock_period_meter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/clock_period_meter_if.sv
// Control and result bundle of clock_period_meter.
// The master side sets enable/sig_in and reads the results; the slave side is the meter.
interface clock_period_meter_if #(
  parameter int unsigned CNT_W = 32
);
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;
  logic             busy;

  modport master (
    output enable,
    output sig_in,
    input  period,
    input  high_time,
    input  meas_valid,
    input  timeout,
    input  busy
  );

  modport slave (
    input  enable,
    input  sig_in,
    output period,
    output high_time,
    output meas_valid,
    output timeout,
    output busy
  );
endinterface

// File: rtl/clock_period_meter.sv
// Measures the period and high time of a slow asynchronous square wave in clkin cycles,
// publishing one result per input period and flagging loss of signal with a sticky timeout.
module clock_period_meter #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MAX_COUNT = 250000000
) (
  input  logic                 clkin,
  input  logic                 rst,
  clock_period_meter_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOW  = 2'd1,
    WAIT_RISE = 2'd2,
    MEASURE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             s0, s1, s_prev;
  logic             rise_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;

  // Two-flop synchroniser plus one delayed copy for rising-edge detection
  always_ff @(posedge clkin) begin
    if (rst) begin
      s0     <= 1'b0;
      s1     <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s0     <= bus.sig_in;
      s1     <= s0;
      s_prev <= s1;
    end
  end

  assign rise_c = s1 & ~s_prev;

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (!bus.enable) begin
      // Dropping enable discards any partial count; published results are kept
      state_d = IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          hcnt_d  = '0;
          state_d = WAIT_LOW;
        end
        WAIT_LOW: begin
          // An input already high at start must go low before an edge can count
          if (!s1) begin
            state_d = WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          if (rise_c) begin
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (rise_c) begin
            // The rising-edge cycle is the first count of the next period
            period_d  = cnt_q;
            high_d    = hcnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = CNT_ONE;
            hcnt_d    = CNT_ONE;
          end else if (cnt_q == MAX_CNT) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            hcnt_d    = '0;
            state_d   = WAIT_LOW;
          end else begin
            cnt_d  = cnt_q + CNT_ONE;
            hcnt_d = hcnt_q + CNT_W'(s1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          hcnt_d  = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_valid = valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.busy       = busy_q;

endmodule
